cell_op_sequencer: RTL and testbench
====================================

// Module: cell_op_sequencer
// PURPOSE
//  Frame-level controller for the combinational cell processor.
//  - Accepts one command: opcode, immediate, image dimensions.
//  - Walks the image in raster order.
//  - For each output pixel, fetches the 3x3 neighbourhood(s) from pixel memory
//    and drives the instruction word into the cell processor.
//  - Captures the result and writes it to the output buffer.
//  - Sits between the host command interface, pixel RAM and the cell processor.
// PARAMETERS
//  PIXEL_W  8   pixel width; must match pixel_t in CellProcessingPkg
//  DIM_W    8   width of the img_w / img_h fields (max 255x255)
//  ADDR_W   16  pixel memory address width
//  B_BASE   16'h4000  base address of image B (second operand)
//  OUT_BASE 16'h8000  base address of the output image
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset; synchronous, active-high
//  start      in   1        1-cycle command strobe; honoured only when busy=0
//  opcode     in   opc_t    operation (ADD/ADDI/SUB/SUBI/AVG per package)
//  user_in    in   PIXEL_W  immediate for ADDI/SUBI
//  img_w      in   DIM_W    image width in pixels
//  img_h      in   DIM_W    image height in pixels
//  busy       out  1        high from the cycle after an accepted start until done
//  done       out  1        1-cycle pulse when the frame completes
//  rd_en      out  1        pixel RAM read strobe
//  rd_addr    out  ADDR_W   pixel RAM read address
//  rd_data    in   PIXEL_W  read data; valid exactly 1 cycle after rd_en
//  cp_iw      out  instruction_t  instruction word to the cell processor
//  cp_result  in   pixel_t  cell processor result (combinational from cp_iw)
//  wr_en      out  1        output write strobe
//  wr_addr    out  ADDR_W   output write address
//  wr_data    out  PIXEL_W  output write data
// BEHAVIOUR
//  Reset:
//   - State returns to IDLE.
//   - busy, done, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0.
//   - cp_iw is all-zero.
//   - Reset mid-frame abandons the frame: no further reads or writes, no done.
//  Command latch: on start in IDLE, opcode, user_in, img_w and img_h are registered.
//   Inputs are ignored afterwards. A start while busy=1 is dropped.
//  Zero-size frame: img_w==0 or img_h==0 -> done pulses the cycle after start.
//   No rd_en, no wr_en.
//  FSM: IDLE -> LOAD_A -> [LOAD_B] -> WAIT -> EXEC -> WRITE -> LOAD_A | FIN -> IDLE.
//   - LOAD_A: 9 cycles, one read per cycle, window order r=0..2, c=0..2.
//     Address is clampY(y+r-1)*W + clampX(x+c-1).
//   - Each rd_data is stored into cellA[r][c] 1 cycle after its read.
//   - LOAD_B: entered only for ADD and SUB. 9 reads at B_BASE+same offsets,
//     issued back-to-back after LOAD_A; data is stored into cellB.
//   - WAIT: 1 cycle that captures the last read datum; rd_en=0.
//   - EXEC: cp_iw holds opcode, cellA, cellB and user_in; cp_result is registered.
//   - WRITE: wr_en=1, wr_addr=OUT_BASE+y*W+x, wr_data=registered result.
//     Then x++. At x==W-1: x=0, y++. At the last pixel, go to FIN.
//   - FIN: done=1 for 1 cycle, busy drops in the same cycle; next state is IDLE.
//  Timing per pixel:
//   - Unary ops (ADDI/SUBI/AVG/other): 12 cycles.
//   - Binary ops (ADD/SUB): 21 cycles.
//   - Frame = W*H*per-pixel + 1 (FIN).
//  Borders:
//   - Coordinates are clamped (edge replicate); clampX(v)=0 if v<0, W-1 if v>W-1.
//   - With W==1 or H==1, all window columns or rows read the same pixel.
//  Arithmetic: address math is unsigned ADDR_W bits; overflow wraps silently.
//   cellB is all-zero for unary ops.
// TESTING
//  - 3x3 image A=1..9, AVG -> 9 writes to 0x8000..0x8008, each with 12-cycle spacing.
//    Centre window gives avg=5; corner (0,0) window = {1,1,2,1,1,2,4,4,5}.
//  - 2x2 image, ADD with A=10 and B=20 everywhere -> 4 writes of 30.
//    rd_addr sequence for pixel 0 covers 0x0000/0x0001 then 0x4000/0x4001.
//    21 cycles per pixel; done pulses at cycle 85.
//  - Start with img_w=0 -> done 1 cycle later; no rd_en or wr_en ever asserted.
//  - Second start asserted mid-frame with a different opcode -> ignored.
//    Results match the first command; exactly W*H writes occur.
//  - rst asserted during LOAD_B of pixel 1 -> next cycle rd_en=0, busy=0.
//    No write occurs for pixel 1; a fresh start then runs a full frame correctly.
//  - 1x4 image, ADDI with user_in=5 -> every window column clamps to x=0.
//    Outputs = A+5 per row.

Source files
------------

// File: rtl/cell_op_sequencer.sv
// Frame controller: walks an image in raster order, gathers each 3x3 window from
// pixel RAM, presents it to the combinational cell processor and stores the result.
package CellProcessingPkg;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef enum logic [2:0] {ADD = 3'd0, ADDI, SUB, SUBI, AVG} opc_t;
  typedef pixel_t [2:0][2:0] cell_t;
  typedef struct packed {
    opc_t   opcode;
    cell_t  cell_a;
    cell_t  cell_b;
    pixel_t user_in;
  } instruction_t;
endpackage

module cell_op_sequencer
  import CellProcessingPkg::*;
#(
  parameter int              PIXEL_W  = 8,
  parameter int              DIM_W    = 8,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] B_BASE   = 16'h4000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  opc_t               opcode,
  input  logic [PIXEL_W-1:0] user_in,
  input  logic [DIM_W-1:0]   img_w,
  input  logic [DIM_W-1:0]   img_h,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIXEL_W-1:0] rd_data,
  output instruction_t       cp_iw,
  input  pixel_t             cp_result,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_EXEC, S_WRITE, S_FIN} state_t;

  state_t               state;
  opc_t                 opc_q;
  logic [PIXEL_W-1:0]   user_q;
  logic [DIM_W-1:0]     w_q, h_q, x, y;
  logic [1:0]           rd_r, rd_c, cap_r, cap_c;
  logic                 rd_b, cap_b, cap_en;
  cell_t                cell_a, cell_b;

  logic [1:0]           nxt_r, nxt_c;
  logic                 nxt_b, rd_last, is_bin, last_px;
  logic [DIM_W-1:0]     nx, ny;

  // Edge-replicated window address: out-of-range neighbours collapse onto the border.
  function automatic logic [ADDR_W-1:0] win_addr(input logic is_b,
                                                 input logic [DIM_W-1:0] px, py, w, h,
                                                 input logic [1:0] r, c);
    logic [DIM_W-1:0] cx, cy;
    cx = px;
    cy = py;
    if (c == 2'd0 && px != '0) cx = px - DIM_W'(1);
    else if (c == 2'd2 && px != w - DIM_W'(1)) cx = px + DIM_W'(1);
    if (r == 2'd0 && py != '0) cy = py - DIM_W'(1);
    else if (r == 2'd2 && py != h - DIM_W'(1)) cy = py + DIM_W'(1);
    return (is_b ? B_BASE : '0) + ADDR_W'(cy) * ADDR_W'(w) + ADDR_W'(cx);
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_bin  = (opc_q == ADD) || (opc_q == SUB);
    nxt_c   = rd_c + 2'd1;
    nxt_r   = rd_r;
    nxt_b   = rd_b;
    rd_last = 1'b0;
    if (rd_c == 2'd2) begin
      nxt_c = 2'd0;
      if (rd_r == 2'd2) begin
        nxt_r = 2'd0;
        if (rd_b || !is_bin) rd_last = 1'b1;
        else nxt_b = 1'b1;
      end else begin
        nxt_r = rd_r + 2'd1;
      end
    end
    last_px = (x == w_q - DIM_W'(1)) && (y == h_q - DIM_W'(1));
    nx      = (x == w_q - DIM_W'(1)) ? '0 : x + DIM_W'(1);
    ny      = (x == w_q - DIM_W'(1)) ? y + DIM_W'(1) : y;
  end

  always_comb begin
    cp_iw         = '0;
    cp_iw.opcode  = opc_q;
    cp_iw.cell_a  = cell_a;
    cp_iw.cell_b  = cell_b;
    cp_iw.user_in = user_q;
  end

  // NOTE: the window registers are reset too, because cp_iw must read all-zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      opc_q   <= ADD;
      user_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      x       <= '0;
      y       <= '0;
      rd_r    <= '0;
      rd_c    <= '0;
      rd_b    <= 1'b0;
      cap_r   <= '0;
      cap_c   <= '0;
      cap_b   <= 1'b0;
      cap_en  <= 1'b0;
      cell_a  <= '0;
      cell_b  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      done <= 1'b0;
      // Read data returns one cycle after its strobe, so the slot index is delayed to match.
      if (cap_en) begin
        if (cap_b) cell_b[cap_r][cap_c] <= rd_data;
        else       cell_a[cap_r][cap_c] <= rd_data;
      end
      cap_en <= rd_en;
      cap_r  <= rd_r;
      cap_c  <= rd_c;
      cap_b  <= rd_b;

      case (state)
        S_IDLE: if (start) begin
          opc_q  <= opcode;
          user_q <= user_in;
          w_q    <= img_w;
          h_q    <= img_h;
          x      <= '0;
          y      <= '0;
          cell_b <= '0;
          if (img_w == '0 || img_h == '0) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            state   <= S_LOAD_A;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_r    <= '0;
            rd_c    <= '0;
            rd_b    <= 1'b0;
            rd_addr <= win_addr(1'b0, '0, '0, img_w, img_h, 2'd0, 2'd0);
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          rd_r <= nxt_r;
          rd_c <= nxt_c;
          rd_b <= nxt_b;
          if (rd_last) begin
            rd_en <= 1'b0;
            rd_b  <= 1'b0;
            state <= S_WAIT;
          end else begin
            rd_addr <= win_addr(nxt_b, x, y, w_q, h_q, nxt_r, nxt_c);
            if (nxt_b) state <= S_LOAD_B;
          end
        end
        S_WAIT: state <= S_EXEC;
        S_EXEC: begin
          wr_en   <= 1'b1;
          wr_addr <= OUT_BASE + ADDR_W'(y) * ADDR_W'(w_q) + ADDR_W'(x);
          wr_data <= cp_result;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          wr_en <= 1'b0;
          x     <= nx;
          y     <= ny;
          if (last_px) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_LOAD_A;
            rd_en   <= 1'b1;
            rd_r    <= '0;
            rd_c    <= '0;
            rd_b    <= 1'b0;
            rd_addr <= win_addr(1'b0, nx, ny, w_q, h_q, 2'd0, 2'd0);
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_op_sequencer.sv
// Directed bench for cell_op_sequencer: pixel RAM model, a stand-in cell processor
// and a write log checked against hand-computed results.
module tb_cell_op_sequencer;
  import CellProcessingPkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  opc_t         opcode = ADD;
  logic [7:0]   user_in = '0;
  logic [7:0]   img_w = '0, img_h = '0;
  logic         busy, done, rd_en, wr_en;
  logic [15:0]  rd_addr, wr_addr;
  logic [7:0]   rd_data = '0, wr_data;
  instruction_t cp_iw;
  pixel_t       cp_result;

  cell_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .user_in(user_in),
    .img_w(img_w), .img_h(img_h), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .cp_iw(cp_iw), .cp_result(cp_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int         cyc = 0;
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  cell_t       wq_cell[$];
  logic [15:0] rq_addr[$];

  always @(posedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
      wq_cell.push_back(cp_iw.cell_a);
    end
    if (rd_en) rq_addr.push_back(rd_addr);
    rd_data <= mem[rd_addr];
    cyc     <= cyc + 1;
  end

  // Stand-in processor: AVG is the 3x3 mean of A, the others act on the centre pixel.
  int sum_a;
  always_comb begin
    sum_a = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) sum_a += int'(cp_iw.cell_a[r][c]);
    case (cp_iw.opcode)
      ADD:     cp_result = cp_iw.cell_a[1][1] + cp_iw.cell_b[1][1];
      SUB:     cp_result = cp_iw.cell_a[1][1] - cp_iw.cell_b[1][1];
      ADDI:    cp_result = cp_iw.cell_a[1][1] + cp_iw.user_in;
      SUBI:    cp_result = cp_iw.cell_a[1][1] - cp_iw.user_in;
      AVG:     cp_result = 8'(sum_a / 9);
      default: cp_result = cp_iw.cell_a[1][1];
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input opc_t op, input logic [7:0] u, input logic [7:0] w,
                          input logic [7:0] h, output int s);
    @(negedge clk);
    opcode  = op;
    user_in = u;
    img_w   = w;
    img_h   = h;
    start   = 1'b1;
    s       = cyc;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  int s, s2, dcyc, w0, r0;
  int avg_exp[9] = '{2, 3, 3, 4, 5, 5, 6, 7, 7};
  int corner_v[9] = '{1, 1, 2, 1, 1, 2, 4, 4, 5};
  int rd_exp[18] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001,
                     16'h0002, 16'h0002, 16'h0003, 16'h4000, 16'h4000, 16'h4001,
                     16'h4000, 16'h4000, 16'h4001, 16'h4002, 16'h4002, 16'h4003};
  int col_v[4] = '{3, 7, 11, 200};
  cell_t corner;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    72'(busy), 72'd0);
    check("rst_done",    72'(done), 72'd0);
    check("rst_rd_en",   72'(rd_en), 72'd0);
    check("rst_wr_en",   72'(wr_en), 72'd0);
    check("rst_rd_addr", 72'(rd_addr), 72'd0);
    check("rst_wr_addr", 72'(wr_addr), 72'd0);
    check("rst_wr_data", 72'(wr_data), 72'd0);
    check("rst_cp_iw",   72'(|cp_iw), 72'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3x3 AVG over A = 1..9
    for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) corner[i / 3][i % 3] = 8'(corner_v[i]);
    w0 = wq_addr.size();
    do_start(AVG, 8'd0, 8'd3, 8'd3, s);
    check("avg_busy_after_start", 72'(busy), 72'd1);
    wait_done(300, dcyc);
    check("avg_done_cycle", 72'(dcyc - s), 72'd109);
    check("avg_busy_at_done", 72'(busy), 72'd0);
    check("avg_write_count", 72'(wq_addr.size() - w0), 72'd9);
    check("avg_first_write_cycle", 72'(wq_cyc[w0] - s), 72'd12);
    check("avg_corner_window", 72'(wq_cell[w0]), 72'(corner));
    for (int i = 0; i < 9; i++) begin
      check("avg_addr", 72'(wq_addr[w0 + i]), 72'(16'h8000 + i));
      check("avg_data", 72'(wq_data[w0 + i]), 72'(avg_exp[i]));
      if (i > 0) check("avg_spacing", 72'(wq_cyc[w0 + i] - wq_cyc[w0 + i - 1]), 72'd12);
    end
    @(negedge clk);
    check("avg_done_one_cycle", 72'(done), 72'd0);

    // 2x2 ADD, A = 10, B = 20
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'd10;
      mem[16'h4000 + i] = 8'd20;
    end
    w0 = wq_addr.size();
    r0 = rq_addr.size();
    do_start(ADD, 8'd0, 8'd2, 8'd2, s);
    wait_done(300, dcyc);
    check("add_done_cycle", 72'(dcyc - s), 72'd85);
    check("add_write_count", 72'(wq_addr.size() - w0), 72'd4);
    check("add_read_count", 72'(rq_addr.size() - r0), 72'd72);
    for (int i = 0; i < 18; i++) check("add_rd_addr_px0", 72'(rq_addr[r0 + i]), 72'(rd_exp[i]));
    for (int i = 0; i < 4; i++) begin
      check("add_addr", 72'(wq_addr[w0 + i]), 72'(16'h8000 + i));
      check("add_data", 72'(wq_data[w0 + i]), 72'd30);
      if (i > 0) check("add_spacing", 72'(wq_cyc[w0 + i] - wq_cyc[w0 + i - 1]), 72'd21);
    end

    // Zero-width frame
    w0 = wq_addr.size();
    r0 = rq_addr.size();
    do_start(AVG, 8'd0, 8'd0, 8'd5, s);
    check("zero_done", 72'(done), 72'd1);
    check("zero_busy", 72'(busy), 72'd0);
    repeat (10) @(negedge clk);
    check("zero_no_reads", 72'(rq_addr.size() - r0), 72'd0);
    check("zero_no_writes", 72'(wq_addr.size() - w0), 72'd0);

    // Second start mid-frame is dropped
    w0 = wq_addr.size();
    do_start(ADD, 8'd0, 8'd2, 8'd2, s);
    repeat (30) @(negedge clk);
    do_start(SUBI, 8'd99, 8'd3, 8'd3, s2);
    wait_done(300, dcyc);
    check("drop_done_cycle", 72'(dcyc - s), 72'd85);
    repeat (30) @(negedge clk);
    check("drop_write_count", 72'(wq_addr.size() - w0), 72'd4);
    for (int i = 0; i < 4; i++) check("drop_data", 72'(wq_data[w0 + i]), 72'd30);

    // Reset during LOAD_B of pixel 1
    w0 = wq_addr.size();
    do_start(ADD, 8'd0, 8'd2, 8'd2, s);
    while (cyc < s + 33) @(negedge clk);
    check("rstmid_in_load_b", 72'(rd_addr), 72'h4001);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rd_en", 72'(rd_en), 72'd0);
    check("rstmid_busy", 72'(busy), 72'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rstmid_writes", 72'(wq_addr.size() - w0), 72'd1);
    check("rstmid_no_done", 72'(done), 72'd0);
    w0 = wq_addr.size();
    do_start(ADD, 8'd0, 8'd2, 8'd2, s);
    wait_done(300, dcyc);
    check("rstmid_rerun_done", 72'(dcyc - s), 72'd85);
    check("rstmid_rerun_count", 72'(wq_addr.size() - w0), 72'd4);
    for (int i = 0; i < 4; i++) check("rstmid_rerun_data", 72'(wq_data[w0 + i]), 72'd30);

    // 1x4 ADDI, user_in = 5
    for (int i = 0; i < 4; i++) mem[i] = 8'(col_v[i]);
    w0 = wq_addr.size();
    do_start(ADDI, 8'd5, 8'd1, 8'd4, s);
    wait_done(300, dcyc);
    check("col_done_cycle", 72'(dcyc - s), 72'd49);
    check("col_write_count", 72'(wq_addr.size() - w0), 72'd4);
    for (int i = 0; i < 4; i++) begin
      check("col_addr", 72'(wq_addr[w0 + i]), 72'(16'h8000 + i));
      check("col_data", 72'(wq_data[w0 + i]), 72'(col_v[i] + 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
